operand_loader: RTL

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/operand_loader.sv
// operand_loader: assembles a byte stream into operands, writes them to BRAM and scans the exponent MSB
module operand_loader #(
    parameter int N         = 64,
    parameter int Nlog2     = 6,
    parameter int NUM_OPS   = 3,
    parameter int ABITS     = 8,
    parameter int DBITS     = 64,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic [N-1:0]     tx_e,
    output logic [N-1:0]     tx_n,
    output logic [Nlog2-1:0] tx_e_idx,
    output logic             tx_valid,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);
    localparam int BPW = DBITS / 8;
    localparam int WPO = N / DBITS;
    localparam int BCW = $clog2(BPW + 1);
    localparam int WCW = $clog2(WPO + 1);
    localparam int KCW = $clog2(NUM_OPS + 1);
    localparam int TCW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t           state, state_nxt;
    logic [BCW-1:0]   bcnt;
    logic [WCW-1:0]   wcnt;
    logic [KCW-1:0]   kcnt;
    logic [TCW-1:0]   tcnt;
    logic [DBITS-1:0] word_sr, word_nxt;
    logic [N-1:0]     e_buf, n_buf, e_nxt, n_nxt;
    logic [Nlog2-1:0] bit_ptr;
    logic [ABITS-1:0] addr;
    logic             acc, word_done, op_done, frame_done, timeout_hit, scan_hit;

    // Byte acceptance, frame position flags, packing and BRAM address of the word in flight
    always_comb begin
        acc         = rx_valid && (state == IDLE || state == LOAD);
        word_done   = bcnt == BCW'(BPW - 1);
        op_done     = word_done && wcnt == WCW'(WPO - 1);
        frame_done  = acc && op_done && kcnt == KCW'(NUM_OPS - 1);
        timeout_hit = TIMEOUT > 0 && state == LOAD && !rx_valid && tcnt == TCW'(TIMEOUT - 1);
        scan_hit    = tx_e[bit_ptr] || bit_ptr == '0;
        word_nxt    = MSB_FIRST != 0 ? (word_sr << 8) | DBITS'(rx_byte)
                                     : (word_sr >> 8) | (DBITS'(rx_byte) << (DBITS - 8));
        e_nxt       = MSB_FIRST != 0 ? (e_buf << 8) | N'(rx_byte)
                                     : (e_buf >> 8) | (N'(rx_byte) << (N - 8));
        n_nxt       = MSB_FIRST != 0 ? (n_buf << 8) | N'(rx_byte)
                                     : (n_buf >> 8) | (N'(rx_byte) << (N - 8));
        addr        = ABITS'(kcnt) * ABITS'(WPO) +
                      (MSB_FIRST != 0 ? ABITS'(WPO - 1) - ABITS'(wcnt) : ABITS'(wcnt));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a completed frame takes priority over the idle timeout
    always_comb begin
        state_nxt = state == IDLE ? (rx_valid ? LOAD : IDLE)
                  : state == LOAD ? (frame_done ? SCAN : timeout_hit ? IDLE : LOAD)
                  : state == SCAN ? (scan_hit ? DONE : SCAN)
                  : IDLE;
    end

    // State-decoded outputs
    always_comb begin
        busy     = state != IDLE;
        tx_valid = state == DONE;
    end

    // Byte/word/operand position counters and the idle-cycle counter; a timeout rewinds to byte 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
            wcnt <= '0;
            kcnt <= '0;
            tcnt <= '0;
        end else begin
            if (acc) begin
                bcnt <= word_done ? '0 : bcnt + 1'b1;
                if (word_done) wcnt <= op_done ? '0 : wcnt + 1'b1;
                if (op_done) kcnt <= frame_done ? '0 : kcnt + 1'b1;
            end else if (timeout_hit) begin
                bcnt <= '0;
                wcnt <= '0;
                kcnt <= '0;
            end
            tcnt <= (state == LOAD && !rx_valid && !timeout_hit) ? tcnt + 1'b1 : '0;
        end
    end

    // Word/operand assembly, registered BRAM write port and one-cycle error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_sr     <= '0;
            e_buf       <= '0;
            n_buf       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wr_en <= acc && word_done;
            if (acc) begin
                word_sr <= word_nxt;
                if (kcnt == KCW'(0)) e_buf <= e_nxt;
                if (kcnt == KCW'(1)) n_buf <= n_nxt;
            end
            if (acc && word_done) begin
                wr_addr <= addr;
                wr_data <= word_nxt;
            end
            err_overrun <= rx_valid && (state == SCAN || state == DONE);
            err_timeout <= timeout_hit;
        end
    end

    // Result capture at frame end, then a downward walk over tx_e to find its top set bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_e     <= '0;
            tx_n     <= '0;
            tx_e_idx <= '0;
            bit_ptr  <= '0;
        end else if (frame_done) begin
            tx_e    <= e_buf;
            tx_n    <= kcnt == KCW'(1) ? n_nxt : n_buf;
            bit_ptr <= Nlog2'(N - 1);
        end else if (state == SCAN) begin
            if (scan_hit) tx_e_idx <= bit_ptr;
            else          bit_ptr  <= bit_ptr - 1'b1;
        end
    end
endmodule
